// File: rtl/dump_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dump_pkg : command/reply codes and state encodings for the dumper   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package dump_pkg;

    localparam logic [7:0] CMD_PING = 8'h50;
    localparam logic [7:0] CMD_READ = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    // Command-level sequencing; XMIT/GUARD/TXW live in the handshake block
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARG   = 3'd1,
        S_HDR   = 3'd2,
        S_RD    = 3'd3,
        S_RWAIT = 3'd4,
        S_XFER  = 3'd5
    } dump_state_t;

    typedef enum logic [1:0] {
        HS_IDLE  = 2'd0,
        HS_XMIT  = 2'd1,
        HS_GUARD = 2'd2,
        HS_TXW   = 2'd3
    } hs_state_t;

endpackage
`default_nettype wire

// File: rtl/dump_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dump_if : UART byte pair and BRAM read port seen by the dumper      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface dump_if #(
    parameter int AW = 10
) ();
    logic [7:0]    rx_byte;
    logic          rx_ready;
    logic [7:0]    tx_byte;
    logic          tx_send;
    logic          tx_busy;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_data;
    logic          active;

    modport master (
        input  rx_byte, rx_ready, tx_busy, mem_data,
        output tx_byte, tx_send, mem_addr, mem_rd, active
    );

    modport slave (
        output rx_byte, rx_ready, tx_busy, mem_data,
        input  tx_byte, tx_send, mem_addr, mem_rd, active
    );
endinterface
`default_nettype wire

// File: rtl/dump_tx_hs.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dump_tx_hs : one-byte send/busy handshake (XMIT, GUARD, TXW)        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module dump_tx_hs
    import dump_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       i_req,
    input  wire logic [7:0] i_byte,
    input  wire logic       i_tx_busy,
    output logic            o_tx_send,
    output logic [7:0]      o_tx_byte,
    output logic            o_done
);

    hs_state_t  r_state;
    hs_state_t  w_next;
    logic [7:0] r_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= HS_IDLE;
            r_byte  <= 8'h00;
        end else begin
            r_state <= w_next;
            if (r_state == HS_IDLE && i_req) begin
                r_byte <= i_byte;
            end
        end
    end

    // GUARD skips one busy sample: the transmitter raises busy a cycle late
    always_comb begin
        w_next    = r_state;
        o_tx_send = 1'b0;
        o_done    = 1'b0;
        case (r_state)
            HS_IDLE: begin
                if (i_req) w_next = HS_XMIT;
            end
            HS_XMIT: begin
                if (!i_tx_busy) begin
                    o_tx_send = 1'b1;
                    w_next    = HS_GUARD;
                end
            end
            HS_GUARD: w_next = HS_TXW;
            HS_TXW: begin
                if (!i_tx_busy) begin
                    o_done = 1'b1;
                    w_next = HS_IDLE;
                end
            end
            default: w_next = HS_IDLE;
        endcase
    end

    assign o_tx_byte = r_byte;

endmodule
`default_nettype wire

// File: rtl/bram_dump_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bram_dump_ctrl : UART command parser streaming BRAM ranges back     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module bram_dump_ctrl
    import dump_pkg::*;
#(
    parameter int AW      = 10,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 2_500_000
) (
    input  wire logic clk,
    input  wire logic reset,
    dump_if.master    bus
);

    localparam int               c_TW         = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0]  c_TIMER_LAST = c_TW'(TIMEOUT - 1);
    localparam logic [1:0]       c_RD_LAT     = 2'(RD_LAT);

    dump_state_t     r_state;
    dump_state_t     w_next;
    logic [AW-1:0]   r_addr;
    logic [15:0]     r_count;
    logic [1:0]      r_arg_cnt;
    logic [c_TW-1:0] r_timer;
    logic [1:0]      r_wait;

    logic            w_req;
    logic [7:0]      w_req_byte;
    logic            w_mem_rd;
    logic            w_timeout;
    logic            w_hs_send;
    logic            w_hs_done;
    logic [7:0]      w_hs_byte;

    assign w_timeout = (r_state == S_ARG) && !bus.rx_ready && (r_timer == c_TIMER_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_count   <= 16'd0;
            r_arg_cnt <= 2'd0;
            r_timer   <= '0;
            r_wait    <= 2'd0;
        end else begin
            r_state <= w_next;

            if (r_state == S_IDLE && bus.rx_ready) begin
                r_count   <= 16'd0;
                r_arg_cnt <= 2'd0;
                r_timer   <= '0;
            end

            // Address bits above AW fall off in the size casts
            if (r_state == S_ARG) begin
                if (bus.rx_ready) begin
                    r_arg_cnt <= r_arg_cnt + 2'd1;
                    r_timer   <= '0;
                    case (r_arg_cnt)
                        2'd0:    r_addr <= AW'({bus.rx_byte, 8'h00});
                        2'd1:    r_addr <= r_addr | AW'(bus.rx_byte);
                        2'd2:    r_count[15:8] <= bus.rx_byte;
                        default: r_count[7:0]  <= bus.rx_byte;
                    endcase
                end else begin
                    r_timer <= r_timer + c_TW'(1);
                end
            end

            if (r_state == S_RD) begin
                r_wait <= 2'd1;
            end else if (r_state == S_RWAIT) begin
                r_wait <= r_wait + 2'd1;
            end

            if (r_state == S_XFER && w_hs_send) begin
                r_addr  <= r_addr + AW'(1);
                r_count <= r_count - 16'd1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_req      = 1'b0;
        w_req_byte = 8'h00;
        w_mem_rd   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.rx_ready) begin
                    if (bus.rx_byte == CMD_READ) begin
                        w_next = S_ARG;
                    end else begin
                        w_req      = 1'b1;
                        w_req_byte = (bus.rx_byte == CMD_PING) ? RSP_OK : RSP_ERR;
                        w_next     = S_HDR;
                    end
                end
            end
            S_ARG: begin
                if (w_timeout) begin
                    w_next = S_IDLE;
                end else if (bus.rx_ready && r_arg_cnt == 2'd3) begin
                    w_req      = 1'b1;
                    w_req_byte = CMD_READ;
                    w_next     = S_HDR;
                end
            end
            S_HDR, S_XFER: begin
                if (w_hs_done) begin
                    w_next = (r_count == 16'd0) ? S_IDLE : S_RD;
                end
            end
            S_RD: begin
                w_mem_rd = 1'b1;
                w_next   = S_RWAIT;
            end
            S_RWAIT: begin
                if (r_wait == c_RD_LAT) begin
                    w_req      = 1'b1;
                    w_req_byte = bus.mem_data;
                    w_next     = S_XFER;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    dump_tx_hs u_tx_hs (
        .clk       (clk),
        .reset     (reset),
        .i_req     (w_req),
        .i_byte    (w_req_byte),
        .i_tx_busy (bus.tx_busy),
        .o_tx_send (w_hs_send),
        .o_tx_byte (w_hs_byte),
        .o_done    (w_hs_done)
    );

    assign bus.tx_send  = w_hs_send;
    assign bus.tx_byte  = w_hs_byte;
    assign bus.mem_rd   = w_mem_rd;
    assign bus.mem_addr = r_addr;
    assign bus.active   = (r_state != S_IDLE);

endmodule
`default_nettype wire
